// File: rtl/i2s_tx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_tx_fifo
//   Stereo I2S / left-justified transmitter with an integrated sample-pair FIFO.
//   Pairs are pushed on a ready/valid handshake, SCK is derived from clk by an
//   even divider, and each pair is sent MSB-first into SLOT_W-bit slots
//   (zero padded when DATA_W < SLOT_W).
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   en        transmitter enable; when low the serial outputs are held at 0
//   dout_lft  left sample   (DATA_W)
//   dout_rgt  right sample  (DATA_W)
//   dout_rts  sample pair valid
//   dout_rtr  FIFO not full (combinational from registered level)
//   sck       serial bit clock
//   ws        word select, 0 = left slot, 1 = right slot
//   sd        serial data, changes on the SCK falling edge
//   level     FIFO occupancy in pairs, 0..DEPTH
//   fifo_ovr  high in the cycle a write is dropped because the FIFO is full
//   udr_flag  sticky: a frame started with an empty FIFO
//   udr_clr   clears udr_flag (a new underrun in the same cycle wins)
// -----------------------------------------------------------------------------
module i2s_tx_fifo #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int SCK_DIV = 4,
  parameter int DEPTH   = 4,
  parameter int MODE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        dout_lft,
  input  logic [DATA_W-1:0]        dout_rgt,
  input  logic                     dout_rts,
  output logic                     dout_rtr,
  output logic                     sck,
  output logic                     ws,
  output logic                     sd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     fifo_ovr,
  output logic                     udr_flag,
  input  logic                     udr_clr
);

  localparam int HALF  = SCK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int FRAME = 2 * SLOT_W;
  localparam int B_W   = $clog2(FRAME);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF - 1);
  localparam logic [B_W-1:0]   FRAME_LAST = B_W'(FRAME - 1);
  localparam logic [B_W-1:0]   SLOT_B     = B_W'(SLOT_W);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);

  // Bit presented in left-justified order at frame index idx: MSB first,
  // zero once the slot position runs past the sample width.
  function automatic logic slot_bit(input logic [DATA_W-1:0] l,
                                    input logic [DATA_W-1:0] r,
                                    input int                idx);
    int                p;
    logic [DATA_W-1:0] s;
    p = (idx >= SLOT_W) ? idx - SLOT_W : idx;
    s = (idx >= SLOT_W) ? r : l;
    if (p >= DATA_W) return 1'b0;
    s = s << p;
    return s[DATA_W-1];
  endfunction

  // FIFO storage and pointers
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem_l, mem_r;
  logic                push, pop, fifo_empty;

  // Serialiser state
  logic [DIV_W-1:0]    div_cnt;
  logic                div_tc, fall_evt, frame_start, started;
  logic [B_W-1:0]      b, b_nxt;
  logic [DATA_W-1:0]   lft_q, rgt_q;
  logic [DATA_W-1:0]   ld_lft, ld_rgt;
  logic                sd_nxt;

  assign dout_rtr   = (level != LVL_FULL);
  assign fifo_empty = (level == '0);
  assign push       = dout_rts && dout_rtr;
  assign fifo_ovr   = dout_rts && !dout_rtr;

  assign div_tc      = (div_cnt == DIV_LAST);
  assign fall_evt    = en && div_tc && sck;
  // The first fall after enable always starts a frame, otherwise wrap at the end.
  assign frame_start = fall_evt && (!started || (b == FRAME_LAST));
  assign pop         = frame_start && !fifo_empty;

  assign {mem_l, mem_r} = mem[rd_ptr];
  assign ld_lft = pop ? mem_l : '0;
  assign ld_rgt = pop ? mem_r : '0;

  always_comb begin
    b_nxt  = frame_start ? '0 : b + 1'b1;
    sd_nxt = 1'b0;
    if (MODE == 1) begin
      sd_nxt = frame_start ? slot_bit(ld_lft, ld_rgt, 0)
                           : slot_bit(lft_q, rgt_q, 32'(b_nxt));
    end else begin
      // I2S: one bit late. At frame start the outgoing bit is the last bit of
      // the previous frame, still held in the sample registers before reload.
      sd_nxt = frame_start ? slot_bit(lft_q, rgt_q, FRAME - 1)
                           : slot_bit(lft_q, rgt_q, 32'(b));
    end
  end

  // FIFO write port (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dout_lft, dout_rgt};
  end

  // FIFO control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // SCK divider, bit index and serial outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      sd      <= 1'b0;
      started <= 1'b0;
      b       <= '0;
      lft_q   <= '0;
      rgt_q   <= '0;
    end else if (!en) begin
      // Disabled: hold everything idle and drop any pair in flight.
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      sd      <= 1'b0;
      started <= 1'b0;
      b       <= '0;
      lft_q   <= '0;
      rgt_q   <= '0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) sck <= ~sck;
      if (fall_evt) begin
        started <= 1'b1;
        b       <= b_nxt;
        ws      <= (b_nxt >= SLOT_B);
        sd      <= sd_nxt;
        if (frame_start) begin
          lft_q <= ld_lft;
          rgt_q <= ld_rgt;
        end
      end
    end
  end

  // Sticky underrun: set has priority over clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             udr_flag <= 1'b0;
    else if (frame_start && fifo_empty)   udr_flag <= 1'b1;
    else if (udr_clr)                     udr_flag <= 1'b0;
  end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
module tb_i2s_tx_fifo;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  en_v;
  logic [15:0]   dout_lft, dout_rgt;
  logic          dout_rts, udr_clr;
  logic [N-1:0]  rtr_v, sck_v, ws_v, sd_v, ovr_v, udr_v;
  logic [2:0]    level_v [N];

  // Instance 0: left-justified 16/16, instance 1: I2S 16/16,
  // instance 2: left-justified 16-bit data in 24-bit slots.
  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int M = (i == 1) ? 0 : 1;
    localparam int S = (i == 2) ? 24 : 16;
    i2s_tx_fifo #(.DATA_W(16), .SLOT_W(S), .SCK_DIV(4), .DEPTH(4), .MODE(M)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en_v[i]),
      .dout_lft (dout_lft),
      .dout_rgt (dout_rgt),
      .dout_rts (dout_rts),
      .dout_rtr (rtr_v[i]),
      .sck      (sck_v[i]),
      .ws       (ws_v[i]),
      .sd       (sd_v[i]),
      .level    (level_v[i]),
      .fifo_ovr (ovr_v[i]),
      .udr_flag (udr_v[i]),
      .udr_clr  (udr_clr)
    );
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          act     = 0;
  logic [31:0] q[$];
  logic        prev_last;
  logic        exp_udr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push one pair; ok says whether the bench expects it to be accepted.
  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic ok);
    dout_lft = l; dout_rgt = r; dout_rts = 1'b1;
    #1;
    check("push_rtr", 32'(rtr_v[act]), 32'(ok));
    check("push_ovr", 32'(ovr_v[act]), 32'(!ok));
    if (ok) q.push_back({l, r});
    tick();
    dout_rts = 1'b0;
    #1;
    check("ovr_idle", 32'(ovr_v[act]), 32'd0);
    check("push_level", 32'(level_v[act]), 32'(q.size()));
  endtask

  // Wait for an SCK 1->0 transition on instance idx; ncyc = 0 on timeout.
  task automatic wait_fall(input int idx, output int ncyc);
    logic prev;
    prev = sck_v[idx];
    ncyc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (prev && !sck_v[idx]) begin
        ncyc = k;
        return;
      end
      prev = sck_v[idx];
    end
  endtask

  // Check the first nbits bit periods of a frame against the scoreboard.
  task automatic frame(input int idx, input int slot, input int mode, input int nbits);
    logic [47:0] fr;
    logic [15:0] l, r;
    logic        exp_sd;
    int          nc;
    fr = '0;
    for (int b = 0; b < nbits; b++) begin
      wait_fall(idx, nc);
      check($sformatf("sck_period i%0d b%0d", idx, b), 32'(nc), 32'd4);
      if (b == 0) begin
        if (q.size() > 0) begin
          {l, r} = q.pop_front();
        end else begin
          l = '0; r = '0; exp_udr = 1'b1;
        end
        fr = '0;
        fr[2*slot-1 -: 16] = l;
        fr[slot-1 -: 16]   = r;
        check($sformatf("frame_level i%0d", idx), 32'(level_v[idx]), 32'(q.size()));
        check($sformatf("frame_udr i%0d", idx), 32'(udr_v[idx]), 32'(exp_udr));
      end
      if (mode == 1)   exp_sd = fr[2*slot-1-b];
      else if (b == 0) exp_sd = prev_last;
      else             exp_sd = fr[2*slot-b];
      check($sformatf("ws i%0d b%0d", idx, b), 32'(ws_v[idx]), 32'(b >= slot));
      check($sformatf("sd i%0d b%0d", idx, b), 32'(sd_v[idx]), 32'(exp_sd));
    end
    prev_last = fr[0];
  endtask

  task automatic check_idle(input string tag, input int idx);
    check({tag, "_sck"}, 32'(sck_v[idx]), 32'd0);
    check({tag, "_ws"},  32'(ws_v[idx]),  32'd0);
    check({tag, "_sd"},  32'(sd_v[idx]),  32'd0);
  endtask

  initial begin
    int nc;
    logic [31:0] tmp;
    rst = 1'b1; en_v = '0; dout_lft = '0; dout_rgt = '0; dout_rts = 1'b0; udr_clr = 1'b0;
    prev_last = 1'b0; exp_udr = 1'b0;
    #1 rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      check_idle("rst0", i);
      check("rst0_level", 32'(level_v[i]), 32'd0);
      check("rst0_rtr",   32'(rtr_v[i]),   32'd1);
      check("rst0_ovr",   32'(ovr_v[i]),   32'd0);
      check("rst0_udr",   32'(udr_v[i]),   32'd0);
    end
    rst = 1'b1;
    tick();

    // Left-justified: fill to full, overflow, stream, underrun, clear
    act = 0;
    push(16'hA5C3, 16'h1234, 1'b1);
    push(16'h8001, 16'h7FFE, 1'b1);
    push(16'h0F0F, 16'hF0F0, 1'b1);
    push(16'h3C3C, 16'hC3C3, 1'b1);
    check("full_rtr", 32'(rtr_v[0]), 32'd0);
    push(16'hDEAD, 16'hBEEF, 1'b0);
    en_v[0] = 1'b1;
    for (int f = 0; f < 5; f++) frame(0, 16, 1, 32);
    wait_fall(0, nc);
    check("udr_refall", 32'(nc), 32'd4);
    check("udr_again", 32'(udr_v[0]), 32'd1);
    udr_clr = 1'b1;
    tick();
    udr_clr = 1'b0;
    exp_udr = 1'b0;
    check("udr_clr", 32'(udr_v[0]), 32'd0);
    tick();
    en_v[0] = 1'b0;
    tick();
    check_idle("lj_off", 0);

    // I2S: one-bit delay, en drop mid-frame, restart, underrun, async reset
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1; q.delete(); prev_last = 1'b0; exp_udr = 1'b0;
    tick();
    act = 1;
    push(16'hA5C3, 16'h1234, 1'b1);
    push(16'h8001, 16'h7FFF, 1'b1);
    push(16'h5A5A, 16'hFFFF, 1'b1);
    push(16'h3C3C, 16'hC3C3, 1'b1);
    en_v[1] = 1'b1;
    frame(1, 16, 0, 32);
    frame(1, 16, 0, 32);
    frame(1, 16, 0, 20);
    en_v[1] = 1'b0;
    prev_last = 1'b0;
    tick();
    check_idle("i2s_off", 1);
    check("i2s_off_level", 32'(level_v[1]), 32'(q.size()));
    en_v[1] = 1'b1;
    frame(1, 16, 0, 32);
    frame(1, 16, 0, 32);
    en_v[1] = 1'b0;
    tick();
    push(16'h1111, 16'h2222, 1'b1);
    push(16'h3333, 16'h4444, 1'b1);
    push(16'hFFFF, 16'hFFFF, 1'b1);
    push(16'h5555, 16'h6666, 1'b1);
    en_v[1] = 1'b1;
    wait_fall(1, nc);
    check("mid_fall", 32'(nc), 32'd4);
    tmp = q.pop_front();
    check("mid_level", 32'(level_v[1]), 32'(q.size()));
    repeat (6) tick();
    rst = 1'b0;
    en_v = '0;
    #1;
    check_idle("rst_mid", 1);
    check("rst_mid_level", 32'(level_v[1]), 32'd0);
    check("rst_mid_rtr",   32'(rtr_v[1]),   32'd1);
    check("rst_mid_udr",   32'(udr_v[1]),   32'd0);
    tick();
    rst = 1'b1; q.delete(); prev_last = 1'b0; exp_udr = 1'b0;
    tick();

    // Padding: 16-bit data in 24-bit slots, 48-bit frame
    act = 2;
    push(16'hFFFF, 16'h8001, 1'b1);
    en_v[2] = 1'b1;
    frame(2, 24, 1, 48);
    frame(2, 24, 1, 48);
    en_v[2] = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Parametrised I2S/left-justified stereo transmitter with an integrated sample FIFO. It accepts left/right sample pairs on a ready/valid handshake, generates SCK by dividing the system clock, and serialises each pair MSB-first into a configurable slot width. It sits between the audio datapath and the external DAC pins. Relative to the earlier fixed 16-bit output stage, it adds buffering, a selectable mode, zero padding and sticky overrun/underrun status.

Parameters:
DATA_W, 16, sample width in bits; must satisfy DATA_W <= SLOT_W.
SLOT_W, 16, SCK periods per channel slot; the frame is 2*SLOT_W SCK periods.
SCK_DIV, 4, clk cycles per SCK period; must be even and >= 2.
DEPTH, 4, FIFO depth in stereo pairs; must be a power of 2 and >= 2.
MODE, 0, frame format: 0 = Philips I2S (data delayed one bit after WS), 1 = left-justified.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  transmitter enable.
dout_lft  in  DATA_W  left sample.
dout_rgt  in  DATA_W  right sample.
dout_rts  in  1  sample pair valid.
dout_rtr  out  1  FIFO can accept a pair (not full).
sck  out  1  serial bit clock.
ws  out  1  word select: 0 = left, 1 = right.
sd  out  1  serial data.
level  out  $clog2(DEPTH)+1  FIFO occupancy.
fifo_ovr  out  1  one-cycle pulse when a write is dropped.
udr_flag  out  1  sticky underrun flag.
udr_clr  in  1  clears udr_flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - sck, ws, sd, fifo_ovr and udr_flag are 0; level is 0; dout_rtr is 1.
  - The divider, bit counter and shift registers are cleared.
  - A reset during a frame abandons the frame and empties the FIFO.
- Push handshake:
  - A write occurs when dout_rts=1 and dout_rtr=1.
  - dout_rtr = (level != DEPTH); it is combinational from registered state.
  - dout_rts=1 while full drops the data and gives fifo_ovr=1 for exactly that cycle.
  - A simultaneous push and pop leaves level unchanged. When full, a pop in the same cycle does not enable the push, because dout_rtr is already 0.
- SCK generation:
  - While en=1, a divider counts 0..SCK_DIV/2-1 and sck toggles at the terminal count.
  - A 1->0 toggle is a "fall event".
  - While en=0, the divider is held at 0 and sck, ws and sd are 0; the FIFO still accepts writes.
  - After en rises, the first sck rise is SCK_DIV/2 cycles later and the first fall event is SCK_DIV cycles later.
- Bit index b (0..2*SLOT_W-1):
  - b advances at each fall event and wraps to 0.
  - The first fall event after en rises sets b=0, which is the frame start.
  - ws, sd and b update only at fall events; the receiver samples on the sck rise.
- Frame start (b becomes 0):
  - If the FIFO is non-empty, pop one pair into the left/right shift registers.
  - If the FIFO is empty, load zeros and set udr_flag.
  - udr_clr clears udr_flag. If udr_clr and a new underrun occur in the same cycle, set wins.
- MODE=1 (left-justified):
  - ws = (b >= SLOT_W).
  - sd carries slot bit position p = b mod SLOT_W: sample bit DATA_W-1-p for p < DATA_W, otherwise 0 (padding).
- MODE=0 (I2S):
  - ws is as in MODE=1.
  - sd is delayed one bit: at b, sd carries the bit that MODE=1 would present at b-1.
  - At b=0, sd carries bit 2*SLOT_W-1 of the previous frame: the previous right-sample LSB if DATA_W == SLOT_W, else 0. It is 0 for the first frame after en.
- en falling:
  - Outputs return to 0 immediately (next clock).
  - The pair currently in the shift registers is discarded; the FIFO is untouched.
- level equals the number of stored pairs, 0..DEPTH.

Test Plan:
- Reset: assert rst=0 mid-frame with level=3 -> next sample shows sck=ws=sd=0, level=0, dout_rtr=1, udr_flag=0.
- Left-justified framing (MODE=1, SCK_DIV=4, DATA_W=SLOT_W=16): push L=16'hA5C3, R=16'h1234; raise en -> first fall event at +4 clk.
  - ws=0 for 16 SCK with sd = 1010010111000011, then ws=1 with sd = 0001001000110100.
  - level drops to 0 at the first fall event.
- I2S delay (MODE=0, same data): sd lags ws by one SCK.
  - At b=0, sd=0.
  - At b=1..16, sd carries the A5C3 bits; the right LSB (0) appears at b=0 of the next frame.
- Overflow (DEPTH=4, en=0): push 4 pairs -> dout_rtr falls after the 4th; a 5th push gives a 1-cycle fifo_ovr and level stays 4.
  - Streaming then outputs the first 4 pairs in order.
- Underrun: en=1 with an empty FIFO -> sd=0 for the whole frame and udr_flag=1 from that frame start; a pulse on udr_clr clears it.
- Padding (SLOT_W=24, DATA_W=16, MODE=1): L=16'hFFFF -> 16 ones then 8 zeros in the left slot; the frame is 48 SCK periods.
